// File: rtl/stream_neq_checker_pkg.sv
// neq_pkg: shared types and reset constants for the stream inequality checker.
//   state_t    - burst controller state (IDLE, RUN, DONE)
//   RST_STATE  - controller state after reset
//   RST_FLAG   - reset level of every single-bit flag register
package neq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam state_t RST_STATE = IDLE;
    localparam logic   RST_FLAG  = 1'b0;

endpackage

// File: rtl/stream_neq_checker_if.sv
// stream_neq_checker_if: groups the burst control, word-pair handshake, result
// strobe and statistics signals of stream_neq_checker.
//   master modport: source/consumer side (drives start, len, in_valid, a, b[, mask])
//   slave modport : checker side (drives in_ready, res_*, busy, done, statistics)
// Optional feature macro: NEQ_MASK_EN adds the per-bit compare mask.
interface stream_neq_checker_if #(
    parameter int W     = 6,
    parameter int CNT_W = 8
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
`ifdef NEQ_MASK_EN
    logic [W-1:0]     mask;
`endif
    logic             res_valid;
    logic             res_neq;
    logic [W-1:0]     res_diff;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] mism_cnt;
    logic [CNT_W-1:0] first_idx;
    logic             first_vld;

    modport master (
        output start, len, in_valid, a, b,
`ifdef NEQ_MASK_EN
        output mask,
`endif
        input  in_ready, res_valid, res_neq, res_diff, busy, done,
        input  mism_cnt, first_idx, first_vld
    );

    modport slave (
        input  start, len, in_valid, a, b,
`ifdef NEQ_MASK_EN
        input  mask,
`endif
        output in_ready, res_valid, res_neq, res_diff, busy, done,
        output mism_cnt, first_idx, first_vld
    );

endinterface

// File: rtl/stream_neq_checker_word_neq.sv
// word_neq: combinational word comparator.
//   a, b  in  W  word pair
//   mask  in  W  per-bit compare enable (only with NEQ_MASK_EN)
//   diff  out W  per-bit difference (a ^ b, ANDed with mask when enabled)
//   neq   out 1  any compared bit differs
// Optional feature macro: NEQ_MASK_EN.
module word_neq #(
    parameter int W = 6
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
`ifdef NEQ_MASK_EN
    input  logic [W-1:0] mask,
`endif
    output logic [W-1:0] diff,
    output logic         neq
);

    for (genvar i = 0; i < W; i++) begin : g_bit
`ifdef NEQ_MASK_EN
        assign diff[i] = (a[i] ^ b[i]) & mask[i];
`else
        assign diff[i] = a[i] ^ b[i];
`endif
    end

    assign neq = |diff;

endmodule

// File: rtl/stream_neq_checker.sv
// stream_neq_checker: clocked burst comparator for LEN word pairs.
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    slave modport of stream_neq_checker_if:
//            start/len    begin a burst (sampled in IDLE only)
//            in_valid/in_ready/a/b[/mask]  word-pair handshake
//            res_valid/res_neq/res_diff    registered per-word result (latency 1)
//            busy/done                     burst status
//            mism_cnt/first_idx/first_vld  burst statistics, held until next start
// Optional feature macro: NEQ_MASK_EN (per-bit compare mask).
module stream_neq_checker
    import neq_pkg::*;
#(
    parameter int W     = 6,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_neq_checker_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] idx_q, len_q;
    logic             res_valid_q, res_neq_q, first_vld_q;
    logic [W-1:0]     res_diff_q;
    logic [CNT_W-1:0] mism_q, first_idx_q;

    logic             run, xfer, start_acc, last_word, neq;
    logic [W-1:0]     diff;

    word_neq #(.W(W)) u_word_neq (
        .a    (bus.a),
        .b    (bus.b),
`ifdef NEQ_MASK_EN
        .mask (bus.mask),
`endif
        .diff (diff),
        .neq  (neq)
    );

    assign run       = (state_q == RUN);
    assign xfer      = bus.in_valid & run;
    assign start_acc = (state_q == IDLE) & bus.start;
    assign last_word = (idx_q == len_q - CNT_W'(1));

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = (bus.len == '0) ? DONE : RUN;
            RUN:     if (xfer && last_word) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RST_STATE;
            idx_q       <= '0;
            len_q       <= '0;
            res_valid_q <= RST_FLAG;
            res_neq_q   <= RST_FLAG;
            res_diff_q  <= '0;
            mism_q      <= '0;
            first_idx_q <= '0;
            first_vld_q <= RST_FLAG;
        end else begin
            state_q     <= state_d;
            res_valid_q <= xfer;
            if (start_acc) begin
                // Statistics of the previous burst are kept until here.
                idx_q       <= '0;
                len_q       <= bus.len;
                mism_q      <= '0;
                first_idx_q <= '0;
                first_vld_q <= 1'b0;
            end else if (xfer) begin
                idx_q      <= idx_q + CNT_W'(1);
                res_neq_q  <= neq;
                res_diff_q <= diff;
                if (neq) begin
                    if (mism_q != '1) mism_q <= mism_q + CNT_W'(1);
                    if (!first_vld_q) begin
                        first_idx_q <= idx_q;
                        first_vld_q <= 1'b1;
                    end
                end
            end
        end
    end

    // in_ready is a pure function of state so the source may wait on it.
    assign bus.in_ready  = run;
    assign bus.busy      = run;
    assign bus.done      = (state_q == DONE);
    assign bus.res_valid = res_valid_q;
    assign bus.res_neq   = res_neq_q;
    assign bus.res_diff  = res_diff_q;
    assign bus.mism_cnt  = mism_q;
    assign bus.first_idx = first_idx_q;
    assign bus.first_vld = first_vld_q;

endmodule

// File: tb/tb_stream_neq_checker.sv
// Scoreboard bench for stream_neq_checker: two instances (CNT_W=8 and CNT_W=2).
// Expected per-word results and end-of-burst statistics are queued when stimulus
// is issued; monitors pop and compare on every res_valid / done strobe.
module tb_stream_neq_checker;

    typedef struct packed {
        logic       neq;
        logic [5:0] diff;
    } res_t;

    typedef struct packed {
        logic [7:0] cnt;
        logic [7:0] idx;
        logic       vld;
    } st_t;

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;

    res_t exp_res0[$], exp_res1[$];
    st_t  exp_st0[$],  exp_st1[$];
    res_t r0, r1;
    st_t  s0, s1;

    always #5 clk = ~clk;

    stream_neq_checker_if #(.W(6), .CNT_W(8)) bus0 ();
    stream_neq_checker_if #(.W(6), .CNT_W(2)) bus1 ();

    stream_neq_checker #(.W(6), .CNT_W(8)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    stream_neq_checker #(.W(6), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not expected / not seen", name);
    endtask

    // Monitors: sample away from the rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus0.res_valid) begin
                if (exp_res0.size() == 0) note_fail("dut0_res_unexpected");
                else begin
                    r0 = exp_res0.pop_front();
                    check("dut0_res_neq",  32'(bus0.res_neq),  32'(r0.neq));
                    check("dut0_res_diff", 32'(bus0.res_diff), 32'(r0.diff));
                end
            end
            if (bus0.done) begin
                if (exp_st0.size() == 0) note_fail("dut0_done_unexpected");
                else begin
                    s0 = exp_st0.pop_front();
                    check("dut0_mism_cnt",  32'(bus0.mism_cnt),  32'(s0.cnt));
                    check("dut0_first_vld", 32'(bus0.first_vld), 32'(s0.vld));
                    if (s0.vld) check("dut0_first_idx", 32'(bus0.first_idx), 32'(s0.idx));
                end
            end
            if (bus1.res_valid) begin
                if (exp_res1.size() == 0) note_fail("dut1_res_unexpected");
                else begin
                    r1 = exp_res1.pop_front();
                    check("dut1_res_neq",  32'(bus1.res_neq),  32'(r1.neq));
                    check("dut1_res_diff", 32'(bus1.res_diff), 32'(r1.diff));
                end
            end
            if (bus1.done) begin
                if (exp_st1.size() == 0) note_fail("dut1_done_unexpected");
                else begin
                    s1 = exp_st1.pop_front();
                    check("dut1_mism_cnt",  32'(bus1.mism_cnt),  32'(s1.cnt));
                    check("dut1_first_vld", 32'(bus1.first_vld), 32'(s1.vld));
                    if (s1.vld) check("dut1_first_idx", 32'(bus1.first_idx), 32'(s1.idx));
                end
            end
        end
    end

    task automatic start_burst(input int sel, input logic [7:0] l);
        @(negedge clk);
        if (sel == 0) begin bus0.start = 1'b1; bus0.len = l; end
        else begin bus1.start = 1'b1; bus1.len = l[1:0]; end
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
    endtask

    // Offer one pair; expected result (hand-computed) is queued once the
    // transfer is certain (in_ready seen high with in_valid asserted).
    task automatic send(input int sel, input logic [5:0] av, input logic [5:0] bv,
                        input logic en, input logic [5:0] ed);
        int   n = 0;
        logic rdy;
        res_t e;
        e.neq  = en;
        e.diff = ed;
        @(negedge clk);
        if (sel == 0) begin bus0.in_valid = 1'b1; bus0.a = av; bus0.b = bv; end
        else begin bus1.in_valid = 1'b1; bus1.a = av; bus1.b = bv; end
        rdy = (sel == 0) ? bus0.in_ready : bus1.in_ready;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = (sel == 0) ? bus0.in_ready : bus1.in_ready;
            n++;
        end
        if (!rdy) note_fail("in_ready_timeout");
        else if (sel == 0) exp_res0.push_back(e);
        else exp_res1.push_back(e);
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        bus1.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus0.start = 0; bus0.len = 0; bus0.in_valid = 0; bus0.a = 0; bus0.b = 0;
        bus1.start = 0; bus1.len = 0; bus1.in_valid = 0; bus1.a = 0; bus1.b = 0;
`ifdef NEQ_MASK_EN
        bus0.mask = 6'b111111;
        bus1.mask = 6'b111111;
`endif
        #2;
        check("rst_busy",      32'(bus0.busy),      0);
        check("rst_in_ready",  32'(bus0.in_ready),  0);
        check("rst_done",      32'(bus0.done),      0);
        check("rst_res_valid", 32'(bus0.res_valid), 0);
        check("rst_mism_cnt",  32'(bus0.mism_cnt),  0);
        check("rst_first_vld", 32'(bus0.first_vld), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-burst after 2 of 4 pairs: immediate clear, no done.
        start_burst(0, 8'd4);
        send(0, 6'b000001, 6'b000001, 1'b0, 6'b000000);
        send(0, 6'b000010, 6'b000000, 1'b1, 6'b000010);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",      32'(bus0.busy),      0);
        check("abort_in_ready",  32'(bus0.in_ready),  0);
        check("abort_res_valid", 32'(bus0.res_valid), 0);
        check("abort_res_neq",   32'(bus0.res_neq),   0);
        check("abort_res_diff",  32'(bus0.res_diff),  0);
        check("abort_mism_cnt",  32'(bus0.mism_cnt),  0);
        check("abort_first_idx", 32'(bus0.first_idx), 0);
        check("abort_first_vld", 32'(bus0.first_vld), 0);
        check("abort_done",      32'(bus0.done),      0);
        repeat (3) @(posedge clk);
        #1;
        check("abort_idle_busy", 32'(bus0.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // len=4 main vectors: neq 0,1,1,1; mism=3, first_idx=1.
        exp_st0.push_back('{cnt: 8'd3, idx: 8'd1, vld: 1'b1});
        start_burst(0, 8'd4);
        check("run_busy", 32'(bus0.busy), 1);
        send(0, 6'b000110, 6'b000110, 1'b0, 6'b000000);
        send(0, 6'b101011, 6'b101010, 1'b1, 6'b000001);
        send(0, 6'b111111, 6'b000000, 1'b1, 6'b111111);
        send(0, 6'b000000, 6'b111111, 1'b1, 6'b111111);
        #1;
        check("len4_done_with_last", 32'(bus0.done), 1);
        repeat (3) @(posedge clk);
        #1;
        check("stats_hold_cnt", 32'(bus0.mism_cnt), 3);
        check("stats_hold_idx", 32'(bus0.first_idx), 1);

        // len=0: done one cycle after start, in_ready never high.
        exp_st0.push_back('{cnt: 8'd0, idx: 8'd0, vld: 1'b0});
        start_burst(0, 8'd0);
        check("len0_done",     32'(bus0.done),     1);
        check("len0_in_ready", 32'(bus0.in_ready), 0);
        @(posedge clk);
        #1;
        check("len0_done_gone",  32'(bus0.done),     0);
        check("len0_in_ready_2", 32'(bus0.in_ready), 0);
        repeat (2) @(posedge clk);

        // len=3 gapped valid (1,0,1,0,1), all equal; start during RUN ignored.
        exp_st0.push_back('{cnt: 8'd0, idx: 8'd0, vld: 1'b0});
        start_burst(0, 8'd3);
        send(0, 6'b010101, 6'b010101, 1'b0, 6'b000000);
        @(negedge clk);
        bus0.start = 1'b1;
        bus0.len   = 8'd0;
        @(posedge clk);
        #1;
        bus0.start = 1'b0;
        check("start_in_run_ignored", 32'(bus0.busy), 1);
        send(0, 6'b111000, 6'b111000, 1'b0, 6'b000000);
        @(posedge clk);
        send(0, 6'b000001, 6'b000001, 1'b0, 6'b000000);
        repeat (3) @(posedge clk);

        // CNT_W=2 instance, len=3, all differ: mism=3 (all-ones), first_idx=0.
        exp_st1.push_back('{cnt: 8'd3, idx: 8'd0, vld: 1'b1});
        start_burst(1, 8'd3);
        send(1, 6'b000001, 6'b000000, 1'b1, 6'b000001);
        send(1, 6'b110000, 6'b000000, 1'b1, 6'b110000);
        send(1, 6'b101010, 6'b010101, 1'b1, 6'b111111);
        repeat (3) @(posedge clk);
        #1;
        check("sat_mism_cnt", 32'(bus1.mism_cnt), 3);

`ifdef NEQ_MASK_EN
        // Masked LSB: 101011 vs 101010 compares equal.
        bus0.mask = 6'b111110;
        exp_st0.push_back('{cnt: 8'd0, idx: 8'd0, vld: 1'b0});
        start_burst(0, 8'd1);
        send(0, 6'b101011, 6'b101010, 1'b0, 6'b000000);
        repeat (3) @(posedge clk);
        bus0.mask = 6'b111111;
`endif

        repeat (3) @(posedge clk);
        check("dut0_res_drained", 32'(exp_res0.size()), 0);
        check("dut0_st_drained",  32'(exp_st0.size()),  0);
        check("dut1_res_drained", 32'(exp_res1.size()), 0);
        check("dut1_st_drained",  32'(exp_st1.size()),  0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
